sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//   Synchronous initiator for the 16x256 asynchronous SRAM (active-low chip/write/output enables).
//   Turns a single-clock valid/ready request into correctly sequenced SRAM strobes.
//   Drives the bidirectional data bus only while writing.
//   Returns one response per request: read data, or a write acknowledge.
// PARAMETERS
//   DATA_WIDTH    16  SRAM data bus width
//   ADDR_WIDTH    8   SRAM address width
//   SETUP_CYCLES  1   address/data setup, chip enabled, before strobe (>=1)
//   PULSE_CYCLES  2   write_enable low time (>=1)
//   HOLD_CYCLES   1   data/address hold after write_enable rises (>=1)
//   READ_CYCLES   2   output_enable low time before data capture (>=1)
// PORTS
//   clock               in     1           rising-edge clock
//   reset               in     1           synchronous reset, active-high
//   req_valid           in     1           request present
//   req_ready           out    1           controller idle; request accepted on valid&&ready edge
//   req_write           in     1           1=write, 0=read
//   req_address         in     ADDR_WIDTH  target address
//   req_wdata           in     DATA_WIDTH  write data
//   resp_valid          out    1           one-cycle pulse: operation complete
//   resp_rdata          out    DATA_WIDTH  read data, valid with resp_valid after a read
//   sram_address        out    ADDR_WIDTH  to SRAM address
//   sram_data           inout  DATA_WIDTH  to SRAM data
//   sram_chip_enable    out    1           active low
//   sram_write_enable   out    1           active low
//   sram_output_enable  out    1           active low
// BEHAVIOUR
//   Reset:
//     - state IDLE; chip/write/output enables 1; sram_data high-Z
//     - sram_address 0; resp_valid 0; resp_rdata 0; req_ready 0 while reset is high
//   req_ready = (state==IDLE) && !reset.
//   On accept: register address, wdata and write. Inputs are ignored until the next IDLE.
//   FSM: IDLE -> SETUP -> {W_PULSE -> W_HOLD | R_WAIT -> TURN} -> IDLE
//     - A down-counter loads the N-1 value for each phase.
//     - The counter is sized clog2 of the largest parameter + 1.
//   SETUP (SETUP_CYCLES): chip_enable=0, write/output enables 1, address stable.
//     - On a write, sram_data is driven.
//   W_PULSE (PULSE_CYCLES): write_enable=0, data driven.
//   W_HOLD (HOLD_CYCLES): write_enable=1, chip_enable=0, data still driven.
//   R_WAIT (READ_CYCLES): output_enable=0, data high-Z.
//     - sram_data is captured into resp_rdata at the edge that ends R_WAIT.
//   TURN (1 cycle): all enables 1, data high-Z.
//     - Provides bus turnaround before a following write.
//   Return to IDLE: all enables 1, data high-Z.
//     - resp_valid=1 for exactly that first IDLE cycle.
//     - resp_rdata is unchanged after a write.
//   Latency from accept edge to resp_valid:
//     - write: SETUP+PULSE+HOLD cycles
//     - read: SETUP+READ+1 cycles
//     - defaults: 4 and 4
//   Back-to-back: a request may be accepted in the resp_valid cycle; no dead cycle beyond TURN.
//   Invariants:
//     - never output_enable=0 while sram_data is driven
//     - never write_enable=0 and output_enable=0 together
//     - sram_address constant while chip_enable=0
//   Address 0 and 2^ADDR_WIDTH-1 need no special handling; no wrap or arithmetic on the address.
//   Reset mid-operation:
//     - next edge forces IDLE-reset values: strobes deasserted, driver off
//     - no resp_valid; the in-flight request is dropped
//   req_valid while busy: no effect; the requester must hold until req_ready.
// TESTING
//   1. reset high 3 cycles, mid-bus
//        -> enables all 1, sram_data Z, req_ready 0
//        -> req_ready 1 the cycle after reset falls
//   2. write 8'h10=16'hA5A5, then read 8'h10
//        -> resp_valid 4 cycles after each accept
//        -> resp_rdata=16'hA5A5
//   3. write 8'hFF=16'h1234
//        -> write_enable low exactly 2 cycles
//        -> address/data stable for the whole chip_enable-low window
//        -> contention checker silent
//   4. read 8'hFF issued in the write's resp_valid cycle
//        -> accepted immediately, resp_rdata=16'h1234
//        -> read 8'h00 after write 8'h00=16'hFFFF returns 16'hFFFF
//   5. pulse SRAM model reset, read 8'hF2
//        -> resp_rdata=16'h0078
//        -> read 8'hF3 gives 16'h0000
//   6. reset asserted during W_PULSE
//        -> write_enable=1, chip_enable=1 next edge, no resp_valid
//        -> held req_valid re-accepted after reset; completes normally

Source files
------------

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - valid/ready request to sequenced async SRAM strobes
// One request in flight; every strobe and the bus-driver enable come straight from flops.
module sram_controller #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int READ_CYCLES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_chip_enable,
  output logic                  sram_write_enable,
  output logic                  sram_output_enable
);

  localparam int MAX_AB  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CD  = (HOLD_CYCLES > READ_CYCLES) ? HOLD_CYCLES : READ_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_WAIT  = 3'd4,
    TURN    = 3'd5
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ce_n_q;
  logic                    we_n_q;
  logic                    oe_n_q;
  logic                    drive_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    resp_valid_q;

  assign req_ready          = (state_q == IDLE) && !reset;
  assign resp_valid         = resp_valid_q;
  assign resp_rdata         = rdata_q;
  assign sram_address       = addr_q;
  assign sram_chip_enable   = ce_n_q;
  assign sram_write_enable  = we_n_q;
  assign sram_output_enable = oe_n_q;
  assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      drive_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_address;
            wdata_q <= req_wdata;
            write_q <= req_write;
            ce_n_q  <= 1'b0;
            drive_q <= req_write;
            cnt_q   <= SETUP_LD;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (write_q) begin
            we_n_q  <= 1'b0;
            cnt_q   <= PULSE_LD;
            state_q <= W_PULSE;
          end else begin
            oe_n_q  <= 1'b0;
            cnt_q   <= READ_LD;
            state_q <= R_WAIT;
          end
        end
        W_PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            we_n_q  <= 1'b1;
            cnt_q   <= HOLD_LD;
            state_q <= W_HOLD;
          end
        end
        W_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            ce_n_q       <= 1'b1;
            drive_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        R_WAIT: begin
          // Capture on the same edge that releases output_enable; SRAM data is still valid here.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rdata_q <= sram_data;
            oe_n_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            state_q <= TURN;
          end
        end
        TURN: begin
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed bench for sram_controller with an async SRAM model
// Undriven bus floats to all-ones through tri1, which stands in for high-Z.
module tb_sram_controller;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_address;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [7:0]  sram_address;
  tri1  [15:0] sram_data;
  logic        sram_chip_enable;
  logic        sram_write_enable;
  logic        sram_output_enable;

  int          vectors;
  int          miscompares;
  logic        model_rst;
  logic [15:0] mem [256];
  logic [15:0] last_rdata;
  logic [15:0] cur_wdata;
  int          we_run;
  logic        prev_ce_low;
  logic [7:0]  prev_addr;

  sram_controller dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_address        (req_address),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_rdata         (resp_rdata),
    .sram_address       (sram_address),
    .sram_data          (sram_data),
    .sram_chip_enable   (sram_chip_enable),
    .sram_write_enable  (sram_write_enable),
    .sram_output_enable (sram_output_enable)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Async SRAM: reset preloads 0xF2 with 0x0078, everything else 0.
  assign sram_data = (!sram_chip_enable && !sram_output_enable && sram_write_enable)
                     ? mem[sram_address] : 16'hzzzz;

  always @(model_rst, sram_write_enable, sram_chip_enable, sram_address, sram_data) begin
    if (model_rst) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'hF2] = 16'h0078;
    end else if (!sram_chip_enable && !sram_write_enable) begin
      mem[sram_address] = sram_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    check("we_oe_overlap", {31'd0, !sram_write_enable && !sram_output_enable}, 32'd0);
    if (!reset && !sram_write_enable)
      check("wdata_during_pulse", {16'd0, sram_data}, {16'd0, cur_wdata});
    if (!sram_chip_enable && prev_ce_low)
      check("addr_stable", {24'd0, sram_address}, {24'd0, prev_addr});
    prev_ce_low = !sram_chip_enable;
    prev_addr   = sram_address;
    if (reset) begin
      we_run = 0;
    end else if (!sram_write_enable) begin
      we_run++;
    end else if (we_run != 0) begin
      check("we_low_cycles", we_run, 32'd2);
      we_run = 0;
    end
  end

  task automatic wait_resp(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rdata, input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_wdata   = wd;
    if (wr) cur_wdata = wd;
    tick();
    req_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
    wait_resp(4, tag);
    if (!wr) last_rdata = exp_rdata;
    check({tag, "_rdata"}, {16'd0, resp_rdata}, {16'd0, last_rdata});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    we_run      = 0;
    prev_ce_low = 1'b0;
    prev_addr   = 8'h00;
    cur_wdata   = 16'h0000;
    last_rdata  = 16'h0000;
    reset       = 1'b1;
    model_rst   = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = 8'h00;
    req_wdata   = 16'h0000;

    // 1: reset state
    repeat (3) @(posedge clock);
    #1;
    model_rst = 1'b0;
    check("rst_ce", {31'd0, sram_chip_enable}, 32'd1);
    check("rst_we", {31'd0, sram_write_enable}, 32'd1);
    check("rst_oe", {31'd0, sram_output_enable}, 32'd1);
    check("rst_bus_z", {16'd0, sram_data}, 32'h0000FFFF);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_addr", {24'd0, sram_address}, 32'd0);
    check("rst_rdata", {16'd0, resp_rdata}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // 2: write then read 0x10
    do_req(1'b1, 8'h10, 16'hA5A5, 16'h0000, "wr10");
    do_req(1'b0, 8'h10, 16'h0000, 16'hA5A5, "rd10");

    // 3: write 0xFF stepped cycle by cycle
    check("wrFF_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'hFF; req_wdata = 16'h1234;
    cur_wdata = 16'h1234;
    tick();
    req_valid = 1'b0;
    check("wrFF_setup_ce", {31'd0, sram_chip_enable}, 32'd0);
    check("wrFF_setup_we", {31'd0, sram_write_enable}, 32'd1);
    check("wrFF_setup_data", {16'd0, sram_data}, 32'h00001234);
    check("wrFF_setup_addr", {24'd0, sram_address}, 32'h000000FF);
    tick();
    check("wrFF_pulse1_we", {31'd0, sram_write_enable}, 32'd0);
    tick();
    check("wrFF_pulse2_we", {31'd0, sram_write_enable}, 32'd0);
    tick();
    check("wrFF_hold_we", {31'd0, sram_write_enable}, 32'd1);
    check("wrFF_hold_ce", {31'd0, sram_chip_enable}, 32'd0);
    check("wrFF_hold_data", {16'd0, sram_data}, 32'h00001234);
    tick();
    check("wrFF_resp", {31'd0, resp_valid}, 32'd1);
    check("wrFF_ce_off", {31'd0, sram_chip_enable}, 32'd1);
    check("wrFF_rdata_kept", {16'd0, resp_rdata}, 32'h0000A5A5);

    // 4: back-to-back read in the write's resp_valid cycle
    do_req(1'b0, 8'hFF, 16'h0000, 16'h1234, "rdFF");
    do_req(1'b1, 8'h00, 16'hFFFF, 16'h0000, "wr00");
    do_req(1'b0, 8'h00, 16'h0000, 16'hFFFF, "rd00");

    // 5: model reset, preloaded contents
    model_rst = 1'b1;
    #1;
    model_rst = 1'b0;
    do_req(1'b0, 8'hF2, 16'h0000, 16'h0078, "rdF2");
    do_req(1'b0, 8'hF3, 16'h0000, 16'h0000, "rdF3");

    // 6: reset during W_PULSE, requester holds valid
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'h55; req_wdata = 16'hBEEF;
    cur_wdata = 16'hBEEF;
    tick();
    tick();
    check("abort_in_pulse", {31'd0, sram_write_enable}, 32'd0);
    reset = 1'b1;
    tick();
    check("abort_we", {31'd0, sram_write_enable}, 32'd1);
    check("abort_ce", {31'd0, sram_chip_enable}, 32'd1);
    check("abort_resp", {31'd0, resp_valid}, 32'd0);
    check("abort_bus_z", {16'd0, sram_data}, 32'h0000FFFF);
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    last_rdata = 16'h0000;
    #1;
    check("reaccept_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    wait_resp(4, "reaccept");
    check("reaccept_rdata", {16'd0, resp_rdata}, 32'd0);
    do_req(1'b0, 8'h55, 16'h0000, 16'hBEEF, "rd55");

    tick();
    check("idle_no_resp", {31'd0, resp_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
